// File: rtl/elevador_pkg.sv
// Shared types and floor constants for the elevator car controller.
package elevador_pkg;

    localparam int unsigned LARGURA_ANDAR = 4;

    localparam logic [LARGURA_ANDAR-1:0] ANDAR_VAZIO = 4'd0;
    localparam logic [LARGURA_ANDAR-1:0] ANDAR_MIN   = 4'd1;
    localparam logic [LARGURA_ANDAR-1:0] ANDAR_MAX   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_MOVING,
        ST_DOOR_OPEN,
        ST_SHIFT,
        ST_SETTLE
    } estado_t;

endpackage

// File: rtl/temporizador_descendente.sv
// Loadable down-counter that saturates at zero; shared by travel and door phases.
module temporizador_descendente #(
    parameter int unsigned LARGURA = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [LARGURA-1:0] valor,
    output logic               zero
);

    logic [LARGURA-1:0] r_cont;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cont <= '0;
        end else if (load) begin
            r_cont <= valor;
        end else if (r_cont != '0) begin
            r_cont <= r_cont - LARGURA'(1);
        end
    end

    assign zero = (r_cont == '0);

endmodule

// File: rtl/controle_cabine_elevador.sv
// Car motion controller: serves the queue head floor by floor, dwells at the door, pops the request.
module controle_cabine_elevador
    import elevador_pkg::*;
#(
    parameter int unsigned T_ANDAR       = 8,
    parameter int unsigned T_PORTA       = 16,
    parameter int unsigned ANDAR_INICIAL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LARGURA_ANDAR-1:0] cabeca,
    input  logic                     sensor_porta,
    output logic                     shift,
    output logic [LARGURA_ANDAR-1:0] andar_atual,
    output logic [LARGURA_ANDAR-1:0] andar_alvo,
    output logic                     sobe,
    output logic                     desce,
    output logic                     porta_aberta,
    output logic                     ocupado
);

    localparam int unsigned T_MAIOR   = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
    localparam int unsigned LARGURA_T = $clog2(T_MAIOR) + 1;
    localparam logic [LARGURA_T-1:0] CARGA_ANDAR = LARGURA_T'(T_ANDAR - 1);
    localparam logic [LARGURA_T-1:0] CARGA_PORTA = LARGURA_T'(T_PORTA - 1);

    estado_t                  r_estado;
    logic                     w_zero;
    logic                     w_load;
    logic [LARGURA_T-1:0]     w_valor;
    logic [LARGURA_ANDAR-1:0] w_prox;
    logic                     w_satura;

    temporizador_descendente #(
        .LARGURA (LARGURA_T)
    ) u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .valor (w_valor),
        .zero  (w_zero)
    );

    // Timer reload: whenever MOVING or DOOR_OPEN is (re)entered, or the door sensor trips.
    always_comb begin
        w_satura = (sobe && (andar_atual == ANDAR_MAX)) || (desce && (andar_atual == ANDAR_MIN));
        w_prox   = sobe ? (andar_atual + LARGURA_ANDAR'(1)) : (andar_atual - LARGURA_ANDAR'(1));
        w_load   = 1'b0;
        w_valor  = CARGA_ANDAR;
        case (r_estado)
            ST_DECIDE: begin
                if (cabeca != ANDAR_VAZIO) begin
                    w_load = 1'b1;
                    if (cabeca == andar_atual) w_valor = CARGA_PORTA;
                end
            end
            ST_MOVING: begin
                if (w_zero && !w_satura && (cabeca != ANDAR_VAZIO)) begin
                    w_load = 1'b1;
                    if (cabeca == w_prox) w_valor = CARGA_PORTA;
                end
            end
            ST_DOOR_OPEN: begin
                if (sensor_porta) begin
                    w_load  = 1'b1;
                    w_valor = CARGA_PORTA;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= ST_IDLE;
            andar_atual  <= LARGURA_ANDAR'(ANDAR_INICIAL);
            andar_alvo   <= ANDAR_VAZIO;
            shift        <= 1'b0;
            sobe         <= 1'b0;
            desce        <= 1'b0;
            porta_aberta <= 1'b0;
            ocupado      <= 1'b0;
        end else begin
            shift <= 1'b0;
            case (r_estado)
                ST_IDLE: begin
                    if (cabeca != ANDAR_VAZIO) begin
                        r_estado <= ST_DECIDE;
                        ocupado  <= 1'b1;
                    end
                end
                ST_DECIDE: begin
                    if (cabeca == ANDAR_VAZIO) begin
                        r_estado   <= ST_IDLE;
                        ocupado    <= 1'b0;
                        andar_alvo <= ANDAR_VAZIO;
                    end else begin
                        andar_alvo <= cabeca;
                        if (cabeca == andar_atual) begin
                            r_estado     <= ST_DOOR_OPEN;
                            porta_aberta <= 1'b1;
                        end else begin
                            r_estado <= ST_MOVING;
                            sobe     <= (cabeca > andar_atual);
                            desce    <= (cabeca < andar_atual);
                        end
                    end
                end
                // Floor boundary: step first, then re-evaluate the head against the new floor.
                ST_MOVING: begin
                    if (w_zero) begin
                        if (w_satura) begin
                            sobe     <= 1'b0;
                            desce    <= 1'b0;
                            r_estado <= ST_DECIDE;
                        end else begin
                            andar_atual <= w_prox;
                            if (cabeca == ANDAR_VAZIO) begin
                                sobe       <= 1'b0;
                                desce      <= 1'b0;
                                r_estado   <= ST_IDLE;
                                ocupado    <= 1'b0;
                                andar_alvo <= ANDAR_VAZIO;
                            end else begin
                                andar_alvo <= cabeca;
                                if (cabeca == w_prox) begin
                                    sobe         <= 1'b0;
                                    desce        <= 1'b0;
                                    r_estado     <= ST_DOOR_OPEN;
                                    porta_aberta <= 1'b1;
                                end else begin
                                    sobe  <= (cabeca > w_prox);
                                    desce <= (cabeca < w_prox);
                                end
                            end
                        end
                    end
                end
                ST_DOOR_OPEN: begin
                    if (w_zero && !sensor_porta) begin
                        porta_aberta <= 1'b0;
                        if (cabeca != ANDAR_VAZIO) begin
                            r_estado <= ST_SHIFT;
                            shift    <= 1'b1;
                        end else begin
                            r_estado   <= ST_IDLE;
                            ocupado    <= 1'b0;
                            andar_alvo <= ANDAR_VAZIO;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_estado <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_estado   <= ST_IDLE;
                    ocupado    <= 1'b0;
                    andar_alvo <= ANDAR_VAZIO;
                end
                default: begin
                    r_estado <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_cabine_elevador.sv
// Scoreboard bench for the elevator car controller: stimulus queues expected output events, a monitor checks them.
module tb_controle_cabine_elevador;

    localparam int TA = 8;
    localparam int TP = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cabeca = 4'd0;
    logic       sensor_porta = 1'b0;
    logic       shift;
    logic [3:0] andar_atual;
    logic [3:0] andar_alvo;
    logic       sobe;
    logic       desce;
    logic       porta_aberta;
    logic       ocupado;

    controle_cabine_elevador #(
        .T_ANDAR       (TA),
        .T_PORTA       (TP),
        .ANDAR_INICIAL (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cabeca       (cabeca),
        .sensor_porta (sensor_porta),
        .shift        (shift),
        .andar_atual  (andar_atual),
        .andar_alvo   (andar_alvo),
        .sobe         (sobe),
        .desce        (desce),
        .porta_aberta (porta_aberta),
        .ocupado      (ocupado)
    );

    always #5 clk = ~clk;

    int ciclo = 0;
    always @(posedge clk) ciclo <= ciclo + 1;

    // {andar, alvo, sobe, desce, porta, shift, ocupado}
    typedef struct packed {
        logic [3:0] andar;
        logic [3:0] alvo;
        logic [4:0] flags;
    } saida_t;

    typedef enum logic [2:0] {EV_ANDAR, EV_PORTA, EV_SHIFT, EV_IDLE, EV_SNAP} tipo_t;

    typedef struct {
        tipo_t  tipo;
        int     ciclo;
        saida_t s;
    } esperado_t;

    esperado_t fila_ev[$];
    esperado_t fila_snap[$];
    int total = 0;
    int bad = 0;
    bit fim = 1'b0;
    bit done = 1'b0;

    saida_t w_atual;
    assign w_atual = {andar_atual, andar_alvo, sobe, desce, porta_aberta, shift, ocupado};

    function automatic saida_t mk(input logic [3:0] a, input logic [3:0] al, input logic [4:0] f);
        return {a, al, f};
    endfunction

    task automatic ev(input tipo_t t, input int c, input saida_t s);
        esperado_t e;
        e.tipo = t; e.ciclo = c; e.s = s;
        fila_ev.push_back(e);
    endtask

    task automatic snap(input int c, input saida_t s);
        esperado_t e;
        e.tipo = EV_SNAP; e.ciclo = c; e.s = s;
        fila_snap.push_back(e);
    endtask

    task automatic espera_ate(input int n);
        while (ciclo < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops an expectation whenever the DUT shows an observable event.
    logic [3:0] prev_andar = 4'd1;
    logic       prev_porta = 1'b0;
    logic       prev_ocup  = 1'b0;

    task automatic confere(input tipo_t t);
        esperado_t e;
        total++;
        if (fila_ev.size() == 0) begin
            bad++;
            $display("FAIL evento_inesperado %s ciclo=%0d saida=%h", t.name(), ciclo, w_atual);
        end else begin
            e = fila_ev.pop_front();
            if (e.tipo != t || e.ciclo != ciclo || e.s != w_atual) begin
                bad++;
                $display("FAIL evento_%s obtido tipo=%s ciclo=%0d saida=%h esperado tipo=%s ciclo=%0d saida=%h",
                         t.name(), t.name(), ciclo, w_atual, e.tipo.name(), e.ciclo, e.s);
            end
        end
    endtask

    always @(negedge clk) begin
        esperado_t e;
        if (rst_n) begin
            if (andar_atual != prev_andar) confere(EV_ANDAR);
            if (porta_aberta && !prev_porta) confere(EV_PORTA);
            if (shift) confere(EV_SHIFT);
            if (prev_ocup && !ocupado) confere(EV_IDLE);
            while (fila_ev.size() > 0 && fila_ev[0].ciclo < ciclo) begin
                e = fila_ev.pop_front();
                total++;
                bad++;
                $display("FAIL evento_ausente tipo=%s esperado ciclo=%0d saida=%h agora ciclo=%0d",
                         e.tipo.name(), e.ciclo, e.s, ciclo);
            end
        end
        while (fila_snap.size() > 0 && fila_snap[0].ciclo <= ciclo) begin
            e = fila_snap.pop_front();
            total++;
            if (e.s != w_atual || e.ciclo != ciclo) begin
                bad++;
                $display("FAIL snapshot ciclo=%0d obtido=%h esperado=%h (ciclo esperado %0d)",
                         ciclo, w_atual, e.s, e.ciclo);
            end
        end
        if (fim && !done) begin
            total++;
            if (fila_ev.size() != 0 || fila_snap.size() != 0) begin
                bad++;
                $display("FAIL pendentes obtido ev=%0d snap=%0d esperado 0", fila_ev.size(), fila_snap.size());
            end
            done = 1'b1;
        end
        prev_andar = andar_atual;
        prev_porta = porta_aberta;
        prev_ocup  = ocupado;
    end

    // Simple trip from IDLE: travel, dwell, pop; the bench acts as the queue clearing its head.
    task automatic atende(input logic [3:0] origem, input logic [3:0] destino);
        int c0, n, cd;
        logic up;
        logic [3:0] a;
        c0 = ciclo;
        up = (destino > origem);
        n  = up ? (int'(destino) - int'(origem)) : (int'(origem) - int'(destino));
        for (int k = 1; k <= n; k++) begin
            a = up ? 4'(int'(origem) + k) : 4'(int'(origem) - k);
            if (k < n) ev(EV_ANDAR, c0 + 2 + TA * k, mk(a, destino, {up, !up, 3'b001}));
            else       ev(EV_ANDAR, c0 + 2 + TA * k, mk(a, destino, 5'b00101));
        end
        cd = c0 + 2 + TA * n;
        ev(EV_PORTA, cd, mk(destino, destino, 5'b00101));
        ev(EV_SHIFT, cd + TP, mk(destino, destino, 5'b00011));
        ev(EV_IDLE, cd + TP + 2, mk(destino, 4'd0, 5'b00000));
        cabeca = destino;
        espera_ate(cd + TP + 1);
        cabeca = 4'd0;
        espera_ate(cd + TP + 4);
    endtask

    initial begin
        int c0;
        @(posedge clk);
        #1;
        // Reset values while held in reset, then an idle hold with an empty queue.
        snap(ciclo, mk(4'd1, 4'd0, 5'b00000));
        espera_ate(3);
        rst_n = 1'b1;
        snap(ciclo + 20, mk(4'd1, 4'd0, 5'b00000));
        espera_ate(ciclo + 22);

        // Floor 1 -> 4 going up, then 4 -> 5.
        atende(4'd1, 4'd4);
        atende(4'd4, 4'd5);

        // Request at the current floor: door opens after two cycles, no motion.
        snap(ciclo + 1, mk(4'd5, 4'd0, 5'b00001));
        atende(4'd5, 4'd5);

        // Down to 3, then a trip to 9 redirected to 5 between floors 4 and 5.
        atende(4'd5, 4'd3);
        c0 = ciclo;
        cabeca = 4'd9;
        ev(EV_ANDAR, c0 + 10, mk(4'd4, 4'd9, 5'b10001));
        espera_ate(c0 + 12);
        cabeca = 4'd5;
        ev(EV_ANDAR, c0 + 18, mk(4'd5, 4'd5, 5'b00101));
        ev(EV_PORTA, c0 + 18, mk(4'd5, 4'd5, 5'b00101));
        snap(c0 + 20, mk(4'd5, 4'd5, 5'b00101));
        ev(EV_SHIFT, c0 + 34, mk(4'd5, 4'd5, 5'b00011));
        ev(EV_IDLE, c0 + 36, mk(4'd5, 4'd0, 5'b00000));
        espera_ate(c0 + 35);
        cabeca = 4'd0;
        espera_ate(c0 + 38);

        // Door obstruction every 10 cycles extends the dwell until 16 clear cycles pass.
        c0 = ciclo;
        cabeca = 4'd5;
        ev(EV_PORTA, c0 + 2, mk(4'd5, 4'd5, 5'b00101));
        snap(c0 + 60, mk(4'd5, 4'd5, 5'b00101));
        ev(EV_SHIFT, c0 + 66, mk(4'd5, 4'd5, 5'b00011));
        ev(EV_IDLE, c0 + 68, mk(4'd5, 4'd0, 5'b00000));
        for (int k = 1; k <= 5; k++) begin
            espera_ate(c0 + 10 * k - 1);
            sensor_porta = 1'b1;
            espera_ate(c0 + 10 * k);
            sensor_porta = 1'b0;
        end
        espera_ate(c0 + 67);
        cabeca = 4'd0;
        espera_ate(c0 + 70);

        // Reset mid-trip at floor 7: outputs clear without a clock edge, request abandoned.
        c0 = ciclo;
        cabeca = 4'd9;
        ev(EV_ANDAR, c0 + 10, mk(4'd6, 4'd9, 5'b10001));
        ev(EV_ANDAR, c0 + 18, mk(4'd7, 4'd9, 5'b10001));
        espera_ate(c0 + 20);
        snap(c0 + 20, mk(4'd1, 4'd0, 5'b00000));
        #1;
        rst_n = 1'b0;
        espera_ate(c0 + 23);
        cabeca = 4'd0;
        rst_n = 1'b1;
        snap(c0 + 30, mk(4'd1, 4'd0, 5'b00000));
        espera_ate(c0 + 40);

        fim = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_cabine_elevador.md
# controle_cabine_elevador

Car motion controller downstream of the 16x4 floor-request queue RAM. Each request is a 4-bit floor code; 0 means an empty slot. The controller reads the queue head, moves the car one floor at a time with a timed travel per floor, and holds the door open for a timed dwell. When the dwell ends it pulses `shift` to pop the served request. It is the only consumer of the queue head and the only driver of the queue's `shift` input.

## Interface
Parameters:
- `T_ANDAR`, 8: clock cycles of travel per floor; must be ≥1.
- `T_PORTA`, 16: clock cycles of door dwell; must be ≥1.
- `ANDAR_INICIAL`, 1: floor after reset; range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cabeca`  in  4  queue head. Wired to the RAM `q` output, with the RAM `addr` tied to 0.
- `sensor_porta`  in  1  door obstruction; restarts the dwell timer.
- `shift`  out  1  one-cycle pop pulse to the queue.
- `andar_atual`  out  4  current floor, 1..15.
- `andar_alvo`  out  4  latched target floor; 0 when idle.
- `sobe`  out  1  car moving up.
- `desce`  out  1  car moving down.
- `porta_aberta`  out  1  door open.
- `ocupado`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DECIDE, MOVING, DOOR_OPEN, SHIFT, SETTLE.
- IDLE:
  - `cabeca==0`: stay.
  - Otherwise: go to DECIDE.
- DECIDE: latch `andar_alvo<=cabeca`.
  - Target equals `andar_atual`: go to DOOR_OPEN and load the door timer.
  - Target greater: set `sobe`, go to MOVING.
  - Target smaller: set `desce`, go to MOVING.
  - Entering MOVING loads the travel timer with `T_ANDAR-1`.
- MOVING: the timer decrements each cycle. When the timer is 0, `andar_atual` steps ±1. The step is applied on the same edge as the decision below, which uses the new floor value:
  - `cabeca==0` (queue emptied): clear `sobe`/`desce`, go to IDLE.
  - `cabeca`==new floor: latch the target, clear `sobe`/`desce`, go to DOOR_OPEN.
  - Otherwise: re-latch `andar_alvo<=cabeca`, recompute the direction (a direction reversal is allowed), reload the timer, stay in MOVING.
  - Effect: a request inserted at position 0 mid-trip is honoured at the next floor boundary.
- Floor saturation: `andar_atual` never leaves 1..15. A step that would cross a bound does not change the floor, and the controller goes to DECIDE.
- DOOR_OPEN: `porta_aberta=1`; the timer loads `T_PORTA-1`.
  - `sensor_porta=1` in any cycle reloads `T_PORTA-1`.
  - At timer 0 with `sensor_porta=0`:
    - `cabeca!=0`: go to SHIFT.
    - `cabeca==0`: go to IDLE without a pulse.
- SHIFT: `shift=1` for exactly one cycle, `porta_aberta=0`, then SETTLE.
- SETTLE: one cycle with no action so the queue head reflects the pop; then IDLE.
- Fixed rule: `shift` is never asserted outside SHIFT.

## Timing
Reset:
- Asynchronous; all outputs take their reset values immediately.
- Reset values: state IDLE, `andar_atual=ANDAR_INICIAL`, `andar_alvo=0`, `shift=0`, `sobe=0`, `desce=0`, `porta_aberta=0`, `ocupado=0`, timers 0.
- Reset mid-trip or with the door open abandons the request; no `shift` is issued.

Latencies:
- Request at the current floor, from IDLE: IDLE(1) + DECIDE(1) + DOOR_OPEN(`T_PORTA`) + SHIFT(1) + SETTLE(1).
- Each floor step takes `T_ANDAR` cycles in MOVING.
- Earliest re-read of `cabeca` after `shift`: 2 cycles later, in IDLE.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `elevador_pkg` holds:
  - the state enum;
  - `LARGURA_ANDAR=4`, `ANDAR_VAZIO=4'd0`, `ANDAR_MIN=1`, `ANDAR_MAX=15`.
- One sub-module, `temporizador_descendente`: a loadable down-counter with `load`, `valor`, and `zero` flag. Width is `$clog2(max(T_ANDAR,T_PORTA))+1`. It is shared between the travel and door phases because they never overlap.

## Test plan
- Reset at floor 1, `cabeca`=0 held -> IDLE, `ocupado`=0, `shift` never pulses.
- Floor 1, `cabeca`=4, `T_ANDAR`=8 ->
  - `sobe` high;
  - `andar_atual` steps 2, 3, 4 at 8-cycle intervals;
  - door opens for 16 cycles;
  - single `shift` pulse.
- Floor 5, `cabeca`=5 -> door opens 2 cycles after the head appears, then one `shift` pulse; `sobe` and `desce` never assert.
- Heading to 9 from floor 3: while the car is between floors 4 and 5, change `cabeca` to 5 -> door opens at floor 5, `andar_alvo`=5.
- Door open with `sensor_porta` pulsed every 10 cycles for 50 cycles -> dwell extends, no `shift` until 16 clear cycles have elapsed.
- `rst_n` low mid-trip at floor 7 -> all outputs reset at once; after release the car is at floor 1 and in IDLE.
